// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) arbiter for a single shared memory port, one cycle in flight.
// Optional bus watchdog enabled by defining ARB_TIMEOUT_EN (limit TIMEOUT_CYCLES).
//
// state  | meaning
// IDLE   | no memory cycle active; arbitrate pending requests
// IF_BUS | memory cycle in flight on behalf of the fetch port
// D_BUS  | memory cycle in flight on behalf of the data port
module mem_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic [31:0] if_rdata_o,
   output logic        if_ack_o,
   output logic        if_err_o,
   input  logic        d_req_i,
   input  logic        d_we_i,
   input  logic [3:0]  d_sel_i,
   input  logic [31:0] d_addr_i,
   input  logic [31:0] d_wdata_i,
   output logic [31:0] d_rdata_o,
   output logic        d_ack_o,
   output logic        d_err_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_sel_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_ack_i,
   input  logic        mem_err_i,
   output logic        is_IF_o,
   output logic        is_MEM_o
);

   typedef enum logic [1:0] {IDLE, IF_BUS, D_BUS} state_t;

   state_t state, state_nxt;
   logic   last_d;
   logic   flushed;
   logic   grant_d, grant_if;
   logic   owner_req, timeout, done, give;

`ifdef ARB_TIMEOUT_EN
   logic [7:0] to_cnt;
   assign timeout = (state != IDLE) && (to_cnt == 8'(TIMEOUT_CYCLES)) && !mem_ack_i && !mem_err_i;
`else
   localparam logic [7:0] unused_timeout_cycles = 8'(TIMEOUT_CYCLES);
   assign timeout = 1'b0;
`endif

   // On contention the side not granted last time wins; last_d resets to 0 so data wins first.
   assign grant_d   = (state == IDLE) && d_req_i && (!if_req_i || !last_d);
   assign grant_if  = (state == IDLE) && if_req_i && !grant_d;
   assign owner_req = (state == IF_BUS) ? if_req_i : d_req_i;
   assign done      = (state != IDLE) && (mem_ack_i || mem_err_i || timeout);
   // A requester that dropped its request during the cycle (flush) gets no completion.
   assign give      = done && owner_req && !flushed && !rst_i;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (grant_d)       state_nxt = D_BUS;
            else if (grant_if) state_nxt = IF_BUS;
         end
         IF_BUS, D_BUS: begin
            if (done) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= IDLE;
         last_d      <= 1'b0;
         flushed     <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_sel_o   <= 4'h0;
         mem_addr_o  <= 32'h0;
         mem_wdata_o <= 32'h0;
`ifdef ARB_TIMEOUT_EN
         to_cnt      <= 8'h0;
`endif
      end else begin
         state <= state_nxt;
         if (grant_d || grant_if) begin
            last_d      <= grant_d;
            flushed     <= 1'b0;
            mem_we_o    <= grant_d ? d_we_i    : 1'b0;
            mem_sel_o   <= grant_d ? d_sel_i   : 4'hF;
            mem_addr_o  <= grant_d ? d_addr_i  : if_addr_i;
            mem_wdata_o <= grant_d ? d_wdata_i : 32'h0;
`ifdef ARB_TIMEOUT_EN
            to_cnt      <= 8'h0;
`endif
         end else if (state != IDLE) begin
            if (!owner_req) flushed <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            to_cnt <= to_cnt + 8'h1;
`endif
         end
      end
   end

   assign mem_req_o  = (state != IDLE);
   assign if_ack_o   = give && (state == IF_BUS) && mem_ack_i && !mem_err_i;
   assign if_err_o   = give && (state == IF_BUS) && (mem_err_i || timeout);
   assign d_ack_o    = give && (state == D_BUS) && mem_ack_i && !mem_err_i;
   assign d_err_o    = give && (state == D_BUS) && (mem_err_i || timeout);
   assign if_rdata_o = if_ack_o ? mem_rdata_i : 32'h0;
   assign d_rdata_o  = d_ack_o  ? mem_rdata_i : 32'h0;
   assign is_IF_o    = if_req_i && !if_ack_o && !if_err_o;
   assign is_MEM_o   = d_req_i && !d_ack_o && !d_err_o;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a transaction-level model of the arbiter.
module tb_mem_arbiter;
   localparam int TO = 4;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic [31:0] if_rdata_o;
   logic        if_ack_o, if_err_o;
   logic        d_req_i, d_we_i;
   logic [3:0]  d_sel_i;
   logic [31:0] d_addr_i, d_wdata_i, d_rdata_o;
   logic        d_ack_o, d_err_o;
   logic        mem_req_o, mem_we_o;
   logic [3:0]  mem_sel_o;
   logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
   logic        mem_ack_i, mem_err_i;
   logic        is_IF_o, is_MEM_o;

   always #5 clk_i = ~clk_i;

   mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
      .if_ack_o(if_ack_o), .if_err_o(if_err_o),
      .d_req_i(d_req_i), .d_we_i(d_we_i), .d_sel_i(d_sel_i), .d_addr_i(d_addr_i),
      .d_wdata_i(d_wdata_i), .d_rdata_o(d_rdata_o), .d_ack_o(d_ack_o), .d_err_o(d_err_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_sel_o(mem_sel_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
      .mem_ack_i(mem_ack_i), .mem_err_i(mem_err_i),
      .is_IF_o(is_IF_o), .is_MEM_o(is_MEM_o)
   );

   int checks = 0;
   int errors = 0;

   // Transaction record: the one memory cycle in flight, if any.
   bit          m_known = 0;
   bit          m_busy, m_own_d, m_last_d, m_flush, m_fields_valid;
   int          m_bus_cycles;
   logic        m_we;
   logic [3:0]  m_sel;
   logic [31:0] m_addr, m_wdata;
   bit          last_if_done, last_d_done;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit timeout_now();
`ifdef ARB_TIMEOUT_EN
      return m_busy && (m_bus_cycles == TO) && !mem_ack_i && !mem_err_i;
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit cycle_done();
      return m_busy && (mem_ack_i || mem_err_i || timeout_now());
   endfunction

   task automatic compare();
      bit to, give, if_a, if_e, d_a, d_e;
      last_if_done = 0;
      last_d_done  = 0;
      if (!m_known) return;
      to   = timeout_now();
      give = cycle_done() && !rst_i && !m_flush && (m_own_d ? d_req_i : if_req_i);
      if_a = give && !m_own_d && mem_ack_i && !mem_err_i;
      if_e = give && !m_own_d && (mem_err_i || to);
      d_a  = give && m_own_d && mem_ack_i && !mem_err_i;
      d_e  = give && m_own_d && (mem_err_i || to);
      chk("mem_req", mem_req_o, m_busy);
      if (m_fields_valid) begin
         chk("mem_we", mem_we_o, m_we);
         chk("mem_sel", mem_sel_o, m_sel);
         chk("mem_addr", mem_addr_o, m_addr);
         chk("mem_wdata", mem_wdata_o, m_wdata);
      end
      chk("if_ack", if_ack_o, if_a);
      chk("if_err", if_err_o, if_e);
      chk("d_ack", d_ack_o, d_a);
      chk("d_err", d_err_o, d_e);
      chk("if_rdata", if_rdata_o, if_a ? mem_rdata_i : 32'h0);
      chk("d_rdata", d_rdata_o, d_a ? mem_rdata_i : 32'h0);
      chk("is_IF", is_IF_o, if_req_i && !if_a && !if_e);
      chk("is_MEM", is_MEM_o, d_req_i && !d_a && !d_e);
      last_if_done = if_a || if_e;
      last_d_done  = d_a || d_e;
   endtask

   task automatic model_update();
      bit pick_d;
      if (rst_i) begin
         m_known = 1; m_busy = 0; m_last_d = 0; m_flush = 0; m_fields_valid = 1;
         m_we = 0; m_sel = 0; m_addr = 0; m_wdata = 0;
      end else if (!m_known) begin
      end else if (m_busy) begin
         if (cycle_done()) begin
            m_busy = 0;
            m_fields_valid = 0;
         end else begin
            m_bus_cycles++;
            if (!(m_own_d ? d_req_i : if_req_i)) m_flush = 1;
         end
      end else if (if_req_i || d_req_i) begin
         pick_d = d_req_i && (!if_req_i || !m_last_d);
         m_busy = 1; m_own_d = pick_d; m_last_d = pick_d; m_flush = 0;
         m_bus_cycles = 0; m_fields_valid = 1;
         m_we    = pick_d ? d_we_i : 1'b0;
         m_sel   = pick_d ? d_sel_i : 4'hF;
         m_addr  = pick_d ? d_addr_i : if_addr_i;
         m_wdata = pick_d ? d_wdata_i : 32'h0;
      end
   endtask

   task automatic sample();
      @(negedge clk_i);
   endtask

   task automatic fin();
      compare();
      @(posedge clk_i);
      model_update();
      #1;
   endtask

   task automatic cyc();
      sample();
      fin();
   endtask

   task automatic rst_pulse();
      rst_i = 1; cyc(); rst_i = 0;
   endtask

   initial begin
      rst_i = 1; if_req_i = 0; if_addr_i = 0; d_req_i = 0; d_we_i = 0; d_sel_i = 0;
      d_addr_i = 0; d_wdata_i = 0; mem_rdata_i = 0; mem_ack_i = 0; mem_err_i = 0;
      cyc();
      sample();
      chk("rst mem_req", mem_req_o, 0);
      chk("rst mem_we", mem_we_o, 0);
      chk("rst mem_sel", mem_sel_o, 0);
      chk("rst mem_addr", mem_addr_o, 0);
      chk("rst mem_wdata", mem_wdata_o, 0);
      fin();
      rst_i = 0;

      // Load 0x100 answered in the third bus cycle.
      d_req_i = 1; d_we_i = 0; d_sel_i = 4'hF; d_addr_i = 32'h100;
      sample(); chk("ld is_MEM N", is_MEM_o, 1); chk("ld mem_req N", mem_req_o, 0); fin();
      sample(); chk("ld mem_req N+1", mem_req_o, 1); chk("ld addr", mem_addr_o, 32'h100);
      chk("ld is_MEM N+1", is_MEM_o, 1); fin();
      sample(); chk("ld is_MEM N+2", is_MEM_o, 1); chk("ld no ack N+2", d_ack_o, 0); fin();
      mem_ack_i = 1; mem_rdata_i = 32'hDEADBEEF;
      sample(); chk("ld d_ack", d_ack_o, 1); chk("ld d_rdata", d_rdata_o, 32'hDEADBEEF);
      chk("ld is_MEM N+3", is_MEM_o, 0); chk("ld if_rdata", if_rdata_o, 0); fin();
      d_req_i = 0; mem_ack_i = 0;
      sample(); chk("ld idle mem_req", mem_req_o, 0); fin();

      // Store with partial lanes; command fields must hold until ack.
      d_req_i = 1; d_we_i = 1; d_sel_i = 4'b0011; d_addr_i = 32'h20; d_wdata_i = 32'h55AA00FF;
      cyc();
      d_we_i = 0; d_sel_i = 4'hF; d_addr_i = 32'hFFFF_FFF0; d_wdata_i = 32'h0;
      for (int k = 0; k < 3; k++) begin
         mem_ack_i = (k == 2);
         sample();
         chk("st we", mem_we_o, 1); chk("st sel", mem_sel_o, 4'b0011);
         chk("st addr", mem_addr_o, 32'h20); chk("st wdata", mem_wdata_o, 32'h55AA00FF);
         fin();
      end
      d_req_i = 0; mem_ack_i = 0; cyc();

      // Contention right after reset alternates D, IF, D, IF.
      rst_pulse();
      d_req_i = 1; d_we_i = 0; d_addr_i = 32'h200; if_req_i = 1; if_addr_i = 32'h300;
      for (int g = 0; g < 4; g++) begin
         mem_ack_i = 0; cyc();
         mem_ack_i = 1; mem_rdata_i = 32'h1000 + g;
         sample();
         chk("alt addr", mem_addr_o, (g % 2 == 0) ? 32'h200 : 32'h300);
         chk("alt d_ack", d_ack_o, (g % 2 == 0));
         chk("alt if_ack", if_ack_o, (g % 2 == 1));
         fin();
      end
      d_req_i = 0; if_req_i = 0; mem_ack_i = 0; cyc();

      // Fetch flushed mid-cycle; pending data request served afterwards.
      if_req_i = 1; if_addr_i = 32'h400; cyc();
      if_req_i = 0; d_req_i = 1; d_addr_i = 32'h500; cyc();
      mem_ack_i = 1;
      sample(); chk("flush if_ack", if_ack_o, 0); chk("flush d_ack", d_ack_o, 0); fin();
      mem_ack_i = 0; cyc();
      sample(); chk("flush then d mem_req", mem_req_o, 1); chk("flush then d addr", mem_addr_o, 32'h500); fin();
      mem_ack_i = 1;
      sample(); chk("flush then d_ack", d_ack_o, 1); fin();
      d_req_i = 0; mem_ack_i = 0; cyc();

      // Reset during a data cycle abandons it.
      d_req_i = 1; d_addr_i = 32'h600; cyc();
      rst_i = 1; mem_ack_i = 1;
      sample(); chk("rst bus d_ack", d_ack_o, 0); chk("rst bus d_err", d_err_o, 0); fin();
      rst_i = 0; d_req_i = 0; mem_ack_i = 0;
      sample(); chk("rst bus mem_req", mem_req_o, 0); fin();

`ifdef ARB_TIMEOUT_EN
      d_req_i = 1; d_addr_i = 32'h700; cyc();
      for (int k = 0; k <= TO; k++) begin
         sample(); chk("to mem_req", mem_req_o, 1); chk("to d_err", d_err_o, (k == TO)); fin();
      end
      d_req_i = 0;
      sample(); chk("to idle", mem_req_o, 0); fin();
`endif

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         rst_i = ($urandom_range(0, 299) == 0);
         if (last_if_done) begin
            if_req_i = $urandom_range(0, 1);
            if_addr_i = $urandom & 32'hFFFF_FFFC;
         end else if (if_req_i) begin
            if (m_busy && !m_own_d && $urandom_range(0, 19) == 0) if_req_i = 0;
         end else if ($urandom_range(0, 2) == 0) begin
            if_req_i = 1; if_addr_i = $urandom & 32'hFFFF_FFFC;
         end
         if (last_d_done || (!d_req_i && $urandom_range(0, 2) == 0)) begin
            d_req_i = last_d_done ? 1'($urandom_range(0, 1)) : 1'b1;
            d_we_i = $urandom_range(0, 1); d_sel_i = 4'($urandom);
            d_addr_i = $urandom; d_wdata_i = $urandom;
         end else if (d_req_i && m_busy && m_own_d && $urandom_range(0, 19) == 0) begin
            d_req_i = 0;
         end
         mem_rdata_i = $urandom;
         if (m_busy) begin
            int r = $urandom_range(0, 9);
            mem_ack_i = (r < 3) || (r == 3 && $urandom_range(0, 1) == 1);
            mem_err_i = (r == 3);
         end else begin
            mem_ack_i = ($urandom_range(0, 9) == 0);
            mem_err_i = ($urandom_range(0, 9) == 0);
         end
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, bus-cycle watchdog limit in clocks (1..255); used only with ARB_TIMEOUT_EN.
REQ-002 clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 rst_i  in  1  reset, synchronous, active-high.
REQ-004 if_req_i  in  1  fetch request, level, held until if_ack_o/if_err_o.
REQ-005 if_addr_i  in  32  fetch byte address.
REQ-006 if_rdata_o  out  32  fetched word, valid only with if_ack_o.
REQ-007 if_ack_o  out  1  fetch completion pulse.
REQ-008 if_err_o  out  1  fetch error-completion pulse.
REQ-009 d_req_i  in  1  load/store request, level, held until d_ack_o/d_err_o.
REQ-010 d_we_i  in  1  1 = store, 0 = load.
REQ-011 d_sel_i  in  4  byte lane enables.
REQ-012 d_addr_i  in  32  data byte address.
REQ-013 d_wdata_i  in  32  store data.
REQ-014 d_rdata_o  out  32  load data, valid only with d_ack_o.
REQ-015 d_ack_o  out  1  data completion pulse.
REQ-016 d_err_o  out  1  data error-completion pulse.
REQ-017 mem_req_o  out  1  shared memory port cycle active.
REQ-018 mem_we_o, mem_sel_o, mem_addr_o, mem_wdata_o  out  1/4/32/32  registered command fields.
REQ-019 mem_rdata_i  in  32  memory read data, valid with mem_ack_i.
REQ-020 mem_ack_i  in  1  memory completion.
REQ-021 mem_err_i  in  1  memory error completion; takes precedence over mem_ack_i.
REQ-022 is_IF_o  out  1  fetch outstanding: if_req_i & ~if_ack_o & ~if_err_o (to hazard unit).
REQ-023 is_MEM_o  out  1  data access outstanding: d_req_i & ~d_ack_o & ~d_err_o (to hazard unit).

Function
REQ-024 FSM states IDLE, IF_BUS, D_BUS; one memory cycle in flight at most.
REQ-025 IDLE: d_req_i only -> D_BUS; if_req_i only -> IF_BUS; both -> grant the requester not granted last (last_grant resets to IF, so data wins first); neither -> stay.
REQ-026 On grant, command fields latched from winner (fetch: we=0, sel=4'hF, wdata=0) and mem_req_o=1 from next cycle; fields stable until completion.
REQ-027 Minimum latency: req in cycle N -> mem_req_o in N+1 -> ack_o combinationally in the cycle mem_ack_i=1 (earliest N+1).
REQ-028 Completion cycle: granted requester's ack_o/err_o =1 for exactly that cycle, rdata_o = mem_rdata_i; next state IDLE with mem_req_o=0 for one cycle minimum.
REQ-029 Requester drops req the cycle after completion unless issuing a new request; req high in IDLE is a new transaction.
REQ-030 Fetch flush: if_req_i falling during IF_BUS -> cycle runs to mem completion, if_ack_o/if_err_o suppressed; same rule for d_req_i in D_BUS.
REQ-031 Non-granted requester never sees ack/err; its rdata_o = 0.
REQ-032 mem_ack_i/mem_err_i in IDLE ignored.

Reset
REQ-033 rst_i=1 at an edge: state IDLE, last_grant IF, mem_req_o/mem_we_o=0, mem_sel_o/mem_addr_o/mem_wdata_o=0, timeout counter 0; ack/err outputs 0 while rst_i=1.
REQ-034 Reset mid-cycle abandons the memory cycle; no completion issued to either requester.

Configuration
REQ-035 Macro ARB_TIMEOUT_EN defined: 8-bit counter clears on grant, increments each IF_BUS/D_BUS cycle; when it equals TIMEOUT_CYCLES without mem_ack_i/mem_err_i, granted err_o pulses that cycle, mem_req_o drops, state -> IDLE.
REQ-036 Macro undefined: no counter; arbiter waits indefinitely for mem_ack_i/mem_err_i.

Verification
REQ-037 d_req_i=1 load 0x100, mem_ack_i at N+3 with 0xDEADBEEF -> d_ack_o one pulse at N+3, d_rdata_o=0xDEADBEEF, is_MEM_o 1 for N..N+2.
REQ-038 if_req_i and d_req_i rise same cycle after reset -> data granted first, fetch next; repeated contention alternates D,IF,D,IF.
REQ-039 Store 0x55AA00FF sel 4'b0011 @0x20 -> mem_we_o=1, mem_sel_o=4'b0011, fields stable until mem_ack_i.
REQ-040 if_req_i dropped during IF_BUS -> no if_ack_o; next d_req_i granted after mem_ack_i.
REQ-041 rst_i pulsed during D_BUS -> mem_req_o=0 next cycle, no d_ack_o/d_err_o.
REQ-042 ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, memory silent -> d_err_o pulses 4 cycles after mem_req_o rises, then IDLE.
